// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
//   state_t : arbiter FSM state (IDLE = no owner, OWN = one owner holds grant)
//   NUM_REQ : number of requesters
//   IDX_W   : width of a requester index
//   HOLD_W  : width of the hold counter
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned HOLD_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

endpackage

// File: rtl/enc_onehot4to2.sv
// Combinational one-hot to binary encoder.
//   in  [3:0] : one-hot (or all-zero) vector
//   out [1:0] : index of the set bit; 2'b00 when in is zero
module enc_onehot4to2 (
  input  logic [3:0] in,
  output logic [1:0] out
);

  // Valid only for one-hot or zero inputs, which is all the arbiter produces.
  always_comb begin
    out = {in[3] | in[2], in[3] | in[1]};
  end

endmodule

// File: rtl/arb_rr4_ctrl.sv
// Four-requester round-robin arbiter with a bounded hold time.
// An owner keeps the grant while it requests, for at most MAX_HOLD cycles
// while someone else is waiting; then the grant is taken away (preempt).
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   req   [3:0] : level-sensitive requests
//   grant [3:0] : registered one-hot grant, zero when no owner
//   grant_idx   : binary index of the granted requester
//   grant_valid : grant != 0
//   preempt     : one-cycle pulse when the grant is taken from a still-requesting owner
module arb_rr4_ctrl
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               preempt
);

  state_t              state, state_n;
  logic [IDX_W-1:0]    ptr, ptr_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [NUM_REQ-1:0]  grant_n;
  logic                preempt_n;

  logic [IDX_W-1:0]    owner;
  logic                owner_req;
  logic                expire;
  logic [IDX_W-1:0]    search_start;
  logic [NUM_REQ-1:0]  search_req;
  logic                found;
  logic [IDX_W-1:0]    win_idx;
  logic                handoff;
  logic                preempt_ev;

  // Returns {found, index} of the first set bit of r scanning start, start+1, ... mod 4.
  function automatic logic [IDX_W:0] rr_search(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] idx;
    rr_search = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = start + IDX_W'(k);
      if (!rr_search[IDX_W] && r[idx]) rr_search = {1'b1, idx};
    end
  endfunction

  enc_onehot4to2 u_enc (
    .in  (grant),
    .out (grant_idx)
  );

  assign grant_valid = |grant;
  assign owner       = grant_idx;
  assign owner_req   = req[owner];
  assign expire      = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // The owner is always excluded from the search: in IDLE grant is zero, on
  // release the owner's req is already low, and on expiry it must be skipped.
  assign search_start = (state == IDLE) ? ptr : owner + 2'd1;
  assign search_req   = req & ~grant;
  assign {found, win_idx} = rr_search(search_req, search_start);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      grant    <= grant_n;
      preempt  <= preempt_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    hold_n     = hold_cnt;
    handoff    = 1'b0;
    preempt_ev = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = OWN;
          hold_n  = '0;
          handoff = 1'b1;
        end
      end
      OWN: begin
        if (!owner_req) begin
          // Release (also covers release coinciding with expiry)
          ptr_n  = owner + 2'd1;
          hold_n = '0;
          if (found) handoff = 1'b1;
          else       state_n = IDLE;
        end else if (!expire) begin
          hold_n = hold_cnt + 1'b1;
        end else begin
          // Expiry: hand over if someone else waits, else restart the hold window
          ptr_n  = owner + 2'd1;
          hold_n = '0;
          if (found) begin
            handoff    = 1'b1;
            preempt_ev = 1'b1;
          end
        end
      end
    endcase
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    grant_n   = grant;
    preempt_n = preempt_ev;
    if (state_n == IDLE) begin
      grant_n = '0;
    end else if (handoff) begin
      grant_n          = '0;
      grant_n[win_idx] = 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_rr4_ctrl.sv
// Scoreboard bench for arb_rr4_ctrl: directed req vectors with hand-computed
// grant/grant_idx/preempt expectations queued per clock edge.
module tb_arb_rr4_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       preempt;

  always #5 clk = ~clk;

  arb_rr4_ctrl #(.MAX_HOLD(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .preempt     (preempt)
  );

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] idx;
    logic       p;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one queued expectation per clock edge, compared just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("grant",       grant,              e.g);
        chk("grant_idx",   {2'b00, grant_idx}, {2'b00, e.idx});
        chk("grant_valid", {3'b000, grant_valid}, {3'b000, (e.g != 4'b0000)});
        chk("preempt",     {3'b000, preempt},  {3'b000, e.p});
      end
    end
  end

  // Drive req for the next edge and queue the outputs expected after it
  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] idx,
                      input logic p, input bit rel = 1'b0);
    @(negedge clk);
    req = r;
    if (rel) rst_n = 1'b1;
    sb.push_back(exp_t'({g, idx, p}));
    @(posedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"},   grant,                 4'b0000);
    chk({tag, "_idx"},     {2'b00, grant_idx},    4'b0000);
    chk({tag, "_valid"},   {3'b000, grant_valid}, 4'b0000);
    chk({tag, "_preempt"}, {3'b000, preempt},     4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");

    // Idle after reset release
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
    repeat (2) step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // All request: 0 first, then hand-off to 1 with no bubble
    step(4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b1110, 4'b0010, 2'd1, 1'b0);
    // Release of 1 -> ptr=2 -> 3 wins; then wrap from 3 to 0
    step(4'b1000, 4'b1000, 2'd3, 1'b0);
    step(4'b1001, 4'b1000, 2'd3, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // Reset to bring ptr back to 0
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);

    // Expiry: 0 holds 8 cycles, preempted by 1; 1 holds 8, preempted by 0 (wrap)
    repeat (8) step(4'b0011, 4'b0001, 2'd0, 1'b0);
    step(4'b0011, 4'b0010, 2'd1, 1'b1);
    repeat (7) step(4'b0011, 4'b0010, 2'd1, 1'b0);
    step(4'b0011, 4'b0001, 2'd0, 1'b1);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);          // release -> ptr=1

    // Release on the expiry edge: treated as release, no preempt
    repeat (8) step(4'b0011, 4'b0010, 2'd1, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);          // ptr=1

    // Lone requester keeps the grant through expiry windows
    repeat (20) step(4'b0100, 4'b0100, 2'd2, 1'b0);

    // Asynchronous reset between edges while granted
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    step(4'b1010, 4'b0010, 2'd1, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
    repeat (3) step(4'b0000, 4'b0000, 2'd0, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_rr4_ctrl.md
ARB_RR4_CTRL -- requirements
Module: arb_rr4_ctrl

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive cycles one owner keeps the grant while others wait (legal 2..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request per requester; bit i = requester i; level-sensitive, held until served.
REQ-005 grant  output  4  registered one-hot grant; 4'b0000 when no owner.
REQ-006 grant_idx  output  2  binary index of the set grant bit; 2'b00 when grant==0.
REQ-007 grant_valid  output  1  high whenever grant!=0.
REQ-008 preempt  output  1  one-cycle registered pulse when the grant moves away from an owner whose req is still high.

Function
REQ-009 States: IDLE (no owner), OWN (one owner holds grant); encoded 1 bit.
REQ-010 Internal: ptr[1:0] = highest-priority requester; hold_cnt[3:0] = cycles current owner has held the grant, 0 in its first grant cycle.
REQ-011 Search: winner = first i with req[i]==1 scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4 (3 wraps to 0).
REQ-012 IDLE, req!=0 at edge: next cycle OWN, grant=one-hot(winner), hold_cnt=0; latency one cycle request-to-grant.
REQ-013 IDLE, req==0: remain IDLE, outputs 0.
REQ-014 OWN, req[owner]==1 and hold_cnt<MAX_HOLD-1: grant unchanged, hold_cnt increments.
REQ-015 OWN, req[owner]==0 (release): ptr<=owner+1 mod 4; search from the new ptr on current req; winner found -> grant it next cycle, hold_cnt=0, no bubble; none -> IDLE, grant=0.
REQ-016 OWN, req[owner]==1 and hold_cnt==MAX_HOLD-1 (expiry): ptr<=owner+1 mod 4; search excludes owner; other winner -> grant it next cycle, preempt=1 for that cycle; no other requester -> owner keeps grant, hold_cnt=0, preempt=0.
REQ-017 Grant changes only at clock edges; never more than one grant bit set; no grant to a requester whose req was low at the deciding edge.
REQ-018 Release and expiry in the same cycle (req[owner] low at expiry edge): treated as release, preempt=0.
REQ-019 grant_idx and grant_valid derive combinationally from the registered grant, so they change in the same cycle as grant.
REQ-020 preempt is 0 in every cycle not named in REQ-016.

Reset
REQ-021 rst_n low: immediately (asynchronously) grant=0, grant_idx=0, grant_valid=0, preempt=0, state=IDLE, ptr=0, hold_cnt=0.
REQ-022 Reset mid-grant discards ownership; after rst_n rises, first arbitration uses ptr=0 per REQ-012.

Structure
REQ-023 Shared package arb_pkg holds: state enum (IDLE, OWN), NUM_REQ=4, IDX_W=2, HOLD_W=4.
REQ-024 One sub-module, enc_onehot4to2: combinational one-hot to binary encoder, in[3:0] -> out[1:0], zero input -> 2'b00; instanced once to produce grant_idx from grant.
REQ-025 Search logic, counter and state register reside in arb_rr4_ctrl; no other sub-modules.

Verification
REQ-026 Reset, then req=4'b1111 -> next cycle grant=4'b0001, grant_idx=2'b00; drop req[0] -> next cycle grant=4'b0010, grant_idx=2'b01, no idle cycle.
REQ-027 Wrap: owner 3 with req=4'b1001, drop req[3] -> next cycle grant=4'b0001, grant_idx=2'b00.
REQ-028 Expiry, MAX_HOLD=8: req=4'b0011 held continuously -> grant=4'b0001 for exactly 8 cycles, then grant=4'b0010 with preempt=1 for one cycle.
REQ-029 Lone requester: req=4'b0100 held 20 cycles -> grant=4'b0100 throughout, preempt stays 0.
REQ-030 Async reset mid-grant: rst_n low between edges -> all outputs 0 before next edge; after release with req=4'b1010 -> grant=4'b0010.
REQ-031 Idle: req=4'b0000 -> grant=0, grant_idx=2'b00, grant_valid=0, preempt=0 every cycle.
